// File: rtl/pwm_capture.sv
// Receiver for a two-wire H-bridge PWM drive: recovers period, duty, direction and brake in clk_50 cycles.
// Define PWMCAP_GLITCH_FILTER_EN to insert a 3-sample glitch filter after each synchroniser.
module pwm_capture #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       capture_en,
    input  logic       pwm_a,
    input  logic       pwm_b,
    output logic [7:0] period_count,
    output logic [7:0] duty_count,
    output logic       direction,
    output logic       valid,
    output logic       ovf,
    output logic       brake,
    output logic       idle,
    output logic       stuck_high
);
    localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMO_FIRE = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        BRAKE     = 2'd2
    } state_t;

    state_t        state_q;
    logic [1:0]    a_sync_q, b_sync_q;
    logic          a_s, b_s, pulse_s, rise_s;
    logic          pulse_q;
    logic [7:0]    per_cnt_q, high_cnt_q;
    logic          cur_dir_q, ovf_pend_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    period_q, duty_q;
    logic          direction_q, valid_q, ovf_q, brake_q, idle_q, stuck_q;

    // Two-flop synchronisers on the asynchronous drive lines
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            a_sync_q <= 2'b00;
            b_sync_q <= 2'b00;
        end else begin
            a_sync_q <= {a_sync_q[0], pwm_a};
            b_sync_q <= {b_sync_q[0], pwm_b};
        end
    end

`ifdef PWMCAP_GLITCH_FILTER_EN
    logic [1:0] a_hist_q, b_hist_q;
    logic       a_filt_q, b_filt_q;

    // A line only moves once three consecutive samples agree
    assign a_s = (a_hist_q == {2{a_sync_q[1]}}) ? a_sync_q[1] : a_filt_q;
    assign b_s = (b_hist_q == {2{b_sync_q[1]}}) ? b_sync_q[1] : b_filt_q;

    // Sample history and held filter outputs
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            a_hist_q <= 2'b00;
            b_hist_q <= 2'b00;
            a_filt_q <= 1'b0;
            b_filt_q <= 1'b0;
        end else begin
            a_hist_q <= {a_hist_q[0], a_sync_q[1]};
            b_hist_q <= {b_hist_q[0], b_sync_q[1]};
            a_filt_q <= a_s;
            b_filt_q <= b_s;
        end
    end
`else
    assign a_s = a_sync_q[1];
    assign b_s = b_sync_q[1];
`endif

    assign pulse_s = a_s ^ b_s;
    assign rise_s  = pulse_s & ~pulse_q;

    // Measurement FSM; priority is brake, capture disable, rising edge, timeout
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q     <= WAIT_EDGE;
            pulse_q     <= 1'b0;
            per_cnt_q   <= 8'd0;
            high_cnt_q  <= 8'd0;
            cur_dir_q   <= 1'b0;
            ovf_pend_q  <= 1'b0;
            tmo_cnt_q   <= '0;
            period_q    <= 8'd0;
            duty_q      <= 8'd0;
            direction_q <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            brake_q     <= 1'b0;
            idle_q      <= 1'b0;
            stuck_q     <= 1'b0;
        end else begin
            pulse_q <= pulse_s;
            valid_q <= 1'b0;
            if (a_s && b_s) begin
                state_q <= BRAKE;
                brake_q <= 1'b1;
            end else if (state_q == BRAKE) begin
                state_q   <= WAIT_EDGE;
                brake_q   <= 1'b0;
                tmo_cnt_q <= '0;
            end else if (!capture_en) begin
                state_q   <= WAIT_EDGE;
                tmo_cnt_q <= '0;
            end else if (rise_s) begin
                // A same-line edge closes the period; any other edge just starts a new one
                if (state_q == MEASURE && cur_dir_q == b_s) begin
                    period_q    <= per_cnt_q;
                    duty_q      <= high_cnt_q;
                    direction_q <= cur_dir_q;
                    ovf_q       <= ovf_pend_q;
                    idle_q      <= 1'b0;
                    valid_q     <= 1'b1;
                end
                state_q    <= MEASURE;
                per_cnt_q  <= 8'd1;
                high_cnt_q <= 8'd1;
                ovf_pend_q <= 1'b0;
                cur_dir_q  <= b_s;
                tmo_cnt_q  <= '0;
            end else if (tmo_cnt_q == TMO_FIRE) begin
                // Parking the counter at TMO_MAX stops a repeat report until the next edge
                state_q   <= WAIT_EDGE;
                tmo_cnt_q <= TMO_MAX;
                period_q  <= 8'd0;
                duty_q    <= 8'd0;
                idle_q    <= 1'b1;
                stuck_q   <= a_s | b_s;
                valid_q   <= 1'b1;
            end else begin
                if (tmo_cnt_q != TMO_MAX) begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_ONE;
                end
                if (state_q == MEASURE) begin
                    if (per_cnt_q == 8'd255) begin
                        ovf_pend_q <= 1'b1;
                    end else begin
                        per_cnt_q <= per_cnt_q + 8'd1;
                    end
                    if (pulse_s) begin
                        if (high_cnt_q == 8'd255) begin
                            ovf_pend_q <= 1'b1;
                        end else begin
                            high_cnt_q <= high_cnt_q + 8'd1;
                        end
                    end
                end
            end
        end
    end

    assign period_count = period_q;
    assign duty_count   = duty_q;
    assign direction    = direction_q;
    assign valid        = valid_q;
    assign ovf          = ovf_q;
    assign brake        = brake_q;
    assign idle         = idle_q;
    assign stuck_high   = stuck_q;
endmodule

// File: doc/pwm_capture.md
# pwm_capture

- Measures the two-wire H-bridge PWM drive (motor_1/motor_2 style lines) and recovers period, duty, direction and brake state in clk_50 cycles.
- It is the receiving end of the motor PWM interface. It sits on the drive lines for closed-loop self-check, and for measuring PWM from an external controller.
- Results are 8-bit to match the generator's dutyCycle/period fields, and are published with a one-cycle valid strobe per completed period.

## Interface
- TIMEOUT, 1024: cycles without a rising edge before the input is declared idle; must be > 255.
- clk_50  in  1: system clock, 50 MHz.
- rst_n  in  1: reset, synchronous, active-low.
- capture_en  in  1: 0 holds the block in WAIT_EDGE and suppresses all result updates.
- pwm_a  in  1: drive line A, asynchronous (anticlockwise when pulsing alone).
- pwm_b  in  1: drive line B, asynchronous (clockwise when pulsing alone).
- period_count  out  8: measured period in cycles, saturating.
- duty_count  out  8: measured high time in cycles, saturating.
- direction  out  1: 1 = B pulsing (clockwise), 0 = A pulsing.
- valid  out  1: one-cycle strobe when period_count, duty_count and direction update.
- ovf  out  1: last published period exceeded 255 cycles.
- brake  out  1: both lines high.
- idle  out  1: timeout occurred with no edge; cleared by the next valid.
- stuck_high  out  1: level of the active line at the timeout.

## Operation
- **Input path:** two-flop synchroniser on each of pwm_a and pwm_b gives a_s and b_s; the optional filter follows.
- **Derived signals:** pulse p = a_s ^ b_s. Active line = whichever of a_s/b_s is high. The rising edge is p & ~p_d.
- **States:** WAIT_EDGE, MEASURE, BRAKE. Reset state is WAIT_EDGE.
- **WAIT_EDGE:**
  - On a rising edge with capture_en=1, go to MEASURE.
  - Load per_cnt=1, high_cnt=1, and latch the active line as cur_dir.
  - No valid is produced.
- **MEASURE, every cycle:**
  - per_cnt increments.
  - high_cnt increments while p=1.
  - Both counters saturate at 255; reaching saturation sets the internal ovf_pend.
- **MEASURE, rising edge with the same active line:**
  - Publish period_count=per_cnt, duty_count=high_cnt, direction=cur_dir, ovf=ovf_pend.
  - Clear idle, pulse valid, then reload both counters to 1 and clear ovf_pend.
- **MEASURE, rising edge with a different active line:**
  - Discard the measurement with no valid.
  - Treat the edge as a first edge: reload counters and latch the new cur_dir.
- **Brake:**
  - a_s & b_s in any state goes to BRAKE with brake=1 and the in-flight measurement discarded.
  - Leaving BRAKE (not both high) clears brake and goes to WAIT_EDGE.
- **Timeout:**
  - A timeout counter counts cycles since the last rising edge; it is reset on each edge and in WAIT_EDGE entry.
  - When it reaches TIMEOUT in MEASURE or WAIT_EDGE, go to WAIT_EDGE.
  - Set idle=1 and stuck_high = the active line level (0 if both low).
  - Publish duty_count=0 and period_count=0, and pulse valid once; no repeat until the next edge.
- **capture_en:** deasserting it forces WAIT_EDGE and discards in-flight data. Outputs hold their last values.
- **Counting rule:** per_cnt equals exactly the generator's period value; high_cnt equals its duty value, for 0 < duty < period ≤ 255.
- **Full duty:** duty ≥ period gives no edges and is reported through timeout with stuck_high=1.

## Timing
- **Reset value of every output:** period_count=0, duty_count=0, direction=0, valid=0, ovf=0, brake=0, idle=0, stuck_high=0.
- **Reset effects:** reset clears the synchronisers, counters and state; reset mid-measurement discards the measurement.
- **Result latency:** valid asserts 3 cycles after the raw rising edge that closes the period (2 sync + 1 register), or 5 cycles with the filter.
- **First valid:** earliest at the second rising edge after reset, brake exit or a direction change.
- **Brake latency:** brake asserts 3 cycles after both raw lines go high, and deasserts 3 cycles after either goes low.
- **Simultaneous events, by priority:** reset, then brake, then capture_en=0, then rising edge, then timeout.

## Configuration
- **PWMCAP_GLITCH_FILTER_EN defined:**
  - A 3-sample filter follows each synchroniser; a filtered line changes only after 3 consecutive equal samples.
  - Pulses and gaps shorter than 3 cycles are suppressed.
  - Latency rises by 2 cycles.
  - Period and duty values are unchanged for high and low times ≥ 3 cycles.
- **Not defined:** the synchronised lines are used directly.

## Test plan
- pwm_b pulsing, period 100, high 25, capture_en=1 -> from the second edge: valid each period with period_count=100, duty_count=25, direction=1, ovf=0.
- pwm_a pulsing, period 40, high 10, then switched to pwm_b at the same timing -> direction=0 results, one period with no valid, then direction=1 results with 40/10.
- Both lines high for 20 cycles mid-measurement -> brake=1 within 3 cycles, no valid for the interrupted period, brake=0 after release, and the next valid after two further edges.
- Period 300, high 20 -> period_count=255, duty_count=20, ovf=1; return to period 100 -> ovf=0.
- Lines held low after 3 valid periods -> TIMEOUT cycles later: valid with period_count=0, duty_count=0, idle=1, stuck_high=0. Lines held high instead -> the same with stuck_high=1.
- rst_n=0 for one cycle mid-period -> all outputs 0 next cycle, and no valid until two new edges. With PWMCAP_GLITCH_FILTER_EN, 1-cycle glitches on pwm_a -> no change in results.
